// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: PS/2 keyboard front end for sound_wave.
// Synchronises the raw PS/2 pins, assembles 11-bit frames into bytes and
// decodes make/break/extended sequences into a held-key scancode.
// Optional build macro: PS2_PARITY_CHECK_EN (parity mismatch -> frame error).
// Ports:
//   clock       system clock (only clock domain)
//   resetn      asynchronous active-low reset
//   ps2_clk     raw PS/2 clock pin (asynchronous)
//   ps2_data    raw PS/2 data pin (asynchronous)
//   alphabet    scancode of last accepted non-extended make code
//   go          high while the key in alphabet is held
//   key_event   one-cycle pulse when a new make code is accepted
//   frame_error one-cycle pulse on start/parity/stop/timeout error
module ps2_key_tracker #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] alphabet,
    output logic       go,
    output logic       key_event,
    output logic       frame_error
);
    localparam int unsigned        TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {DEC_NORMAL, DEC_BREAK, DEC_EXT, DEC_EXT_BREAK} dec_state_e;

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic                   clk_s, data_s, fall_c;

    rx_state_e              rx_state_q, rx_state_d;
    logic [7:0]             shift_q, shift_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   rx_err_q, rx_err_d;
    logic                   parity_ok_c;

    dec_state_e             dec_state_q, dec_state_d;
    logic [7:0]             alphabet_q, alphabet_d;
    logic                   go_q, go_d;
    logic                   key_event_q, key_event_d;
    logic                   frame_error_q, frame_error_d;
    logic                   ignored_c;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign fall_c = clk_prev_q & ~clk_s;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_q, parity_d;
    // Odd parity across the eight data bits plus the parity bit.
    assign parity_ok_c = ^{shift_q, parity_q};
`else
    assign parity_ok_c = 1'b1;
`endif

    // Pin synchronisers; idle-high so reset never fakes a falling edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q  <= clk_s;
        end
    end

    // Frame receiver state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rx_state_q   <= RX_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            timer_q      <= '0;
            byte_valid_q <= 1'b0;
            rx_err_q     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            rx_state_q   <= rx_state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            timer_q      <= timer_d;
            byte_valid_q <= byte_valid_d;
            rx_err_q     <= rx_err_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q     <= parity_d;
`endif
        end
    end

    // Frame receiver next state; a falling edge always beats timeout expiry.
    always_comb begin
        rx_state_d   = rx_state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        timer_d      = timer_q;
        byte_valid_d = 1'b0;
        rx_err_d     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_d     = parity_q;
`endif

        if (rx_state_q == RX_IDLE || fall_c) begin
            timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
            timer_d    = '0;
            rx_state_d = RX_IDLE;
            rx_err_d   = 1'b1;
        end else begin
            timer_d = timer_q + TIMER_W'(1);
        end

        if (fall_c) begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (!data_s) begin
                        rx_state_d = RX_DATA;
                        bit_cnt_d  = '0;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end
                RX_DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) rx_state_d = RX_PARITY;
                end
                RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_d   = data_s;
`endif
                    rx_state_d = RX_STOP;
                end
                default: begin
                    rx_state_d = RX_IDLE;
                    if (data_s && parity_ok_c) byte_valid_d = 1'b1;
                    else                       rx_err_d     = 1'b1;
                end
            endcase
        end
    end

    assign ignored_c = (shift_q == 8'h00) || (shift_q == 8'hAA) || (shift_q == 8'hEE) ||
                       (shift_q == 8'hFA) || (shift_q == 8'hFE) || (shift_q == 8'hFF);

    // Byte decoder and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dec_state_q   <= DEC_NORMAL;
            alphabet_q    <= '0;
            go_q          <= 1'b0;
            key_event_q   <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            dec_state_q   <= dec_state_d;
            alphabet_q    <= alphabet_d;
            go_q          <= go_d;
            key_event_q   <= key_event_d;
            frame_error_q <= frame_error_d;
        end
    end

    // Make/break/extended prefix tracking on each valid byte.
    always_comb begin
        dec_state_d   = dec_state_q;
        alphabet_d    = alphabet_q;
        go_d          = go_q;
        key_event_d   = 1'b0;
        frame_error_d = rx_err_q;

        if (byte_valid_q) begin
            if (shift_q == 8'hE0) begin
                dec_state_d = DEC_EXT;
            end else if (shift_q == 8'hF0) begin
                if (dec_state_q == DEC_NORMAL)   dec_state_d = DEC_BREAK;
                else if (dec_state_q == DEC_EXT) dec_state_d = DEC_EXT_BREAK;
            end else if (!ignored_c) begin
                dec_state_d = DEC_NORMAL;
                case (dec_state_q)
                    DEC_NORMAL: begin
                        alphabet_d  = shift_q;
                        go_d        = 1'b1;
                        // Typematic repeats of the held key are silent.
                        key_event_d = (shift_q != alphabet_q) || !go_q;
                    end
                    DEC_BREAK: begin
                        if (shift_q == alphabet_q) go_d = 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign alphabet    = alphabet_q;
    assign go          = go_q;
    assign key_event   = key_event_q;
    assign frame_error = frame_error_q;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed sequences plus random
// frames, compared every cycle against a frame-level behavioural model.
module tb_ps2_key_tracker;
    localparam int unsigned TO = 200;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clock, resetn, ps2_clk, ps2_data;
    logic [7:0] alphabet;
    logic       go, key_event, frame_error;

    ps2_key_tracker #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
        .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .alphabet(alphabet), .go(go), .key_event(key_event), .frame_error(frame_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [7:0] alpha;
        logic       go;
        logic       ke;
        logic       fe;
    } ev_t;
    ev_t evq[$];

    // Model state (written by the stimulus process only)
    logic [7:0] m_alpha;
    logic       m_go, m_ext, m_brk;
    int         last_stop_cyc = 0;

    // Checker state (written by the compare process only)
    int         checks = 0, errors = 0, rd_idx = 0;
    logic [7:0] e_alpha;
    logic       e_go, e_ke, e_fe;
    int         ke_count = 0, fe_count = 0, last_ke_cyc = -100;

    // Literal-check requests handed to the compare process
    int         lit_req = 0, lit_ack = 0;
    string      lit_name;
    logic [7:0] lit_alpha;
    logic       lit_go;
    int         lit_ke, lit_fe;
    bit         lit_lat;

    always @(posedge clock) begin
        #1;
        e_ke = 1'b0;
        e_fe = 1'b0;
        if (!resetn) begin
            e_alpha = 8'h00;
            e_go    = 1'b0;
            rd_idx  = evq.size();
        end else begin
            while (rd_idx < evq.size() && evq[rd_idx].at < cyc) begin
                checks++;
                errors++;
                $display("FAIL sched: event due at cycle %0d not applied, now %0d", evq[rd_idx].at, cyc);
                rd_idx++;
            end
            if (rd_idx < evq.size() && evq[rd_idx].at == cyc) begin
                e_alpha = evq[rd_idx].alpha;
                e_go    = evq[rd_idx].go;
                e_ke    = evq[rd_idx].ke;
                e_fe    = evq[rd_idx].fe;
                rd_idx++;
            end
        end
        checks++;
        if ({alphabet, go, key_event, frame_error} !== {e_alpha, e_go, e_ke, e_fe}) begin
            errors++;
            $display("FAIL cycle %0d: alphabet=%h go=%b key_event=%b frame_error=%b, required %h %b %b %b",
                     cyc, alphabet, go, key_event, frame_error, e_alpha, e_go, e_ke, e_fe);
        end
        if (key_event === 1'b1) begin
            ke_count++;
            last_ke_cyc = cyc;
        end
        if (frame_error === 1'b1) fe_count++;
        if (lit_req != lit_ack) begin
            checks++;
            if (alphabet !== lit_alpha || go !== lit_go) begin
                errors++;
                $display("FAIL %s outputs: alphabet=%h go=%b, required %h %b", lit_name, alphabet, go, lit_alpha, lit_go);
            end
            checks++;
            if (ke_count != lit_ke) begin
                errors++;
                $display("FAIL %s key_event count: %0d, required %0d", lit_name, ke_count, lit_ke);
            end
            checks++;
            if (fe_count != lit_fe) begin
                errors++;
                $display("FAIL %s frame_error count: %0d, required %0d", lit_name, fe_count, lit_fe);
            end
            if (lit_lat) begin
                checks++;
                if (last_ke_cyc - last_stop_cyc != 4) begin
                    errors++;
                    $display("FAIL %s latency: %0d cycles, required 4", lit_name, last_ke_cyc - last_stop_cyc);
                end
            end
            lit_ack = lit_req;
        end
    end

    task automatic expect_lit(input string name, input logic [7:0] a, input logic g,
                              input int kec, input int fec, input bit lat);
        lit_name  = name;
        lit_alpha = a;
        lit_go    = g;
        lit_ke    = kec;
        lit_fe    = fec;
        lit_lat   = lat;
        lit_req++;
        repeat (3) @(negedge clock);
    endtask

    task automatic push_ev(input int at, input logic ke, input logic fe);
        evq.push_back('{at, m_alpha, m_go, ke, fe});
    endtask

    // Decoder rules applied to one accepted byte.
    task automatic model_byte(input logic [7:0] code, input int at);
        logic ke;
        ke = 1'b0;
        if (code == 8'hE0) begin
            m_ext = 1'b1;
            m_brk = 1'b0;
        end else if (code == 8'hF0) begin
            m_brk = 1'b1;
        end else if (!(code inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) begin
            if (!m_ext) begin
                if (m_brk) begin
                    if (code == m_alpha) m_go = 1'b0;
                end else begin
                    ke      = (code != m_alpha) || !m_go;
                    m_alpha = code;
                    m_go    = 1'b1;
                end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        push_ev(at, ke, 1'b0);
    endtask

    task automatic bit_fall(input logic v, output int fc);
        @(negedge clock);
        ps2_data = v;
        repeat (2) @(negedge clock);
        ps2_clk = 1'b0;
        fc = cyc;
    endtask

    task automatic bit_rise();
        repeat (6) @(negedge clock);
        ps2_clk = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int   fc;
        logic p;
        p = (~^b) ^ bad_par;
        bit_fall(1'b0, fc); bit_rise();
        for (int i = 0; i < 8; i++) begin
            bit_fall(b[i], fc); bit_rise();
        end
        bit_fall(p, fc); bit_rise();
        bit_fall(!bad_stop, fc);
        last_stop_cyc = fc;
        if (bad_stop || (PAR_EN && bad_par)) push_ev(fc + 4, 1'b0, 1'b1);
        else                                 model_byte(b, fc + 4);
        bit_rise();
        ps2_data = 1'b1;
    endtask

    task automatic send_bad_start();
        int fc;
        bit_fall(1'b1, fc);
        push_ev(fc + 4, 1'b0, 1'b1);
        bit_rise();
    endtask

    // Start bit plus some data bits, then either abandon (timeout) or return early.
    task automatic send_partial(input int nfalls, input bit do_timeout);
        int fc;
        for (int k = 0; k < nfalls; k++) begin
            bit_fall((k == 0) ? 1'b0 : 1'($urandom_range(0, 1)), fc);
            if (do_timeout && k == nfalls - 1) push_ev(fc + 4 + TO, 1'b0, 1'b1);
            bit_rise();
        end
        ps2_data = 1'b1;
        if (do_timeout) repeat (TO + 10) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn  = 1'b0;
        m_alpha = 8'h00;
        m_go    = 1'b0;
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            ps2_clk  = 1'(i % 2);
            ps2_data = 1'($urandom_range(0, 1));
        end
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    function automatic logic [7:0] pick_byte();
        logic [7:0] pool[8];
        logic [7:0] ign[6];
        int         r;
        pool = '{8'h1C, 8'h32, 8'h21, 8'h24, 8'h2C, 8'h1B, 8'h23, 8'h4B};
        ign  = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
        r = $urandom_range(0, 99);
        if (r < 15)      return 8'hE0;
        else if (r < 30) return 8'hF0;
        else if (r < 36) return ign[$urandom_range(0, 5)];
        else if (r < 58) return m_alpha;
        else if (r < 85) return pool[$urandom_range(0, 7)];
        else             return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        int kec, fec, r;
        resetn   = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        m_alpha  = 8'h00;
        m_go     = 1'b0;
        m_ext    = 1'b0;
        m_brk    = 1'b0;
        #2 resetn = 1'b0;

        do_reset();
        kec = 0;
        fec = 0;
        expect_lit("reset", 8'h00, 1'b0, kec, fec, 1'b0);

        send_frame(8'h1C, 1'b0, 1'b0);
        kec++;
        expect_lit("make_1c", 8'h1C, 1'b1, kec, fec, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b0);
        expect_lit("repeat_1c", 8'h1C, 1'b1, kec, fec, 1'b0);

        send_frame(8'h32, 1'b0, 1'b0);
        kec++;
        expect_lit("make_32", 8'h32, 1'b1, kec, fec, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        expect_lit("break_other", 8'h32, 1'b1, kec, fec, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h32, 1'b0, 1'b0);
        expect_lit("break_32", 8'h32, 1'b0, kec, fec, 1'b0);

        send_frame(8'h2C, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        fec++;
        expect_lit("bad_parity_2c", 8'h32, 1'b0, kec, fec, 1'b0);
`else
        kec++;
        expect_lit("bad_parity_2c", 8'h2C, 1'b1, kec, fec, 1'b0);
`endif

        send_partial(6, 1'b1);
        fec++;
        expect_lit("timeout", m_alpha, m_go, kec, fec, 1'b0);
        send_frame(8'h21, 1'b0, 1'b0);
        kec++;
        expect_lit("after_timeout", 8'h21, 1'b1, kec, fec, 1'b1);

        send_frame(8'h32, 1'b0, 1'b0);
        kec++;
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        expect_lit("extended", 8'h32, 1'b1, kec, fec, 1'b0);

        send_partial(3, 1'b0);
        do_reset();
        expect_lit("mid_reset", 8'h00, 1'b0, kec, fec, 1'b0);
        send_frame(8'h24, 1'b0, 1'b0);
        kec++;
        expect_lit("after_reset", 8'h24, 1'b1, kec, fec, 1'b1);

        send_bad_start();
        fec++;
        expect_lit("bad_start", 8'h24, 1'b1, kec, fec, 1'b0);
        send_frame(8'h24, 1'b0, 1'b1);
        fec++;
        expect_lit("bad_stop", 8'h24, 1'b1, kec, fec, 1'b0);

        for (int n = 0; n < 70; n++) begin
            r = $urandom_range(0, 99);
            if (r < 5)       send_bad_start();
            else if (r < 10) send_partial($urandom_range(1, 10), 1'b1);
            else if (r < 14) begin
                send_partial($urandom_range(1, 9), 1'b0);
                do_reset();
            end
            else if (r < 20) send_frame(pick_byte(), 1'b0, 1'b1);
            else if (r < 28) send_frame(pick_byte(), 1'b1, 1'b0);
            else             send_frame(pick_byte(), 1'b0, 1'b0);
        end

        repeat (10) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
